inst_decode_stage: RTL and testbench

- Instruction-decode (ID) stage; sits directly downstream of the instruction-fetch stage's IF/ID pipeline register.
- Consumes fetched instruction, PC+4 and the fetch-hit valid; holds the 32x32 register file and decodes main control.
- Detects load-use hazards and stalls fetch; resolves `j` and redirects fetch.
- Drives the ID/EX pipeline register consumed by the execute stage.

---
 rtl/inst_decode_stage_if.sv | 36 +++
 rtl/inst_decode_stage.sv | 147 ++++++++++++++
 tb/tb_inst_decode_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_decode_stage_if.sv
// ID/EX pipeline-register bus carried from the decode stage to the execute stage.
// The decode stage drives it through the master modport; execute reads it through the slave modport.
`timescale 1ns/1ps
interface inst_decode_stage_if;
   logic        idex_valid;
   logic [31:0] idex_pc4;
   logic [31:0] idex_rs_data;
   logic [31:0] idex_rt_data;
   logic [31:0] idex_imm;
   logic [4:0]  idex_rs;
   logic [4:0]  idex_rt;
   logic [4:0]  idex_rd;
   logic        idex_regdst;
   logic        idex_alusrc;
   logic        idex_memread;
   logic        idex_memwrite;
   logic        idex_regwrite;
   logic        idex_memtoreg;
   logic        idex_branch;
   logic [1:0]  idex_aluop;
   logic        idex_illegal;

   modport master (
      output idex_valid, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
             idex_rs, idex_rt, idex_rd, idex_regdst, idex_alusrc, idex_memread,
             idex_memwrite, idex_regwrite, idex_memtoreg, idex_branch,
             idex_aluop, idex_illegal
   );

   modport slave (
      input  idex_valid, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
             idex_rs, idex_rt, idex_rd, idex_regdst, idex_alusrc, idex_memread,
             idex_memwrite, idex_regwrite, idex_memtoreg, idex_branch,
             idex_aluop, idex_illegal
   );
endinterface

// File: rtl/inst_decode_stage.sv
// Instruction-decode stage: register file with write bypass, main-control decode,
// load-use stall detection, j redirect, and the ID/EX pipeline register.
`timescale 1ns/1ps
module inst_decode_stage #(
   parameter logic [3:0] RESET_PC_HI = 4'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc4_in,
   input  logic [31:0] instr_in,
   input  logic        valid_in,
   input  logic        flush,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        jump_taken,
   output logic [31:0] jump_addr,
   inst_decode_stage_if.master idex
);

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic       branch;
      logic [1:0] aluop;
      logic       illegal;
   } ctrl_t;

   logic [31:0] regs_q [32];

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_ext;
   logic [31:0] rs_data, rt_data;
   ctrl_t       ctrl_d;
   logic        reads_rt;
   logic        is_jump;
   logic        hazard;
   logic        load_d;

   logic        valid_q;
   ctrl_t       ctrl_q;
   logic [31:0] pc4_q, rs_data_q, rt_data_q, imm_q;
   logic [4:0]  rs_q, rt_q, rd_q;

   assign opcode  = instr_in[31:26];
   assign rs      = instr_in[25:21];
   assign rt      = instr_in[20:16];
   assign rd      = instr_in[15:11];
   assign imm_ext = {{16{instr_in[15]}}, instr_in[15:0]};

   // Writeback in the same cycle is forwarded so ID never sees a stale value.
   always_comb begin
      rs_data = regs_q[rs];
      if (rs == 5'd0)                       rs_data = 32'd0;
      else if (wb_we && (wb_addr == rs))    rs_data = wb_data;
      rt_data = regs_q[rt];
      if (rt == 5'd0)                       rt_data = 32'd0;
      else if (wb_we && (wb_addr == rt))    rt_data = wb_data;
   end

   always_comb begin
      ctrl_d   = '0;
      reads_rt = 1'b0;
      is_jump  = 1'b0;
      case (opcode)
         6'h00: begin ctrl_d.regdst = 1'b1; ctrl_d.regwrite = 1'b1;
                      ctrl_d.aluop = 2'b10; reads_rt = 1'b1; end
         6'h23: begin ctrl_d.alusrc = 1'b1; ctrl_d.memread = 1'b1;
                      ctrl_d.regwrite = 1'b1; ctrl_d.memtoreg = 1'b1; end
         6'h2B: begin ctrl_d.alusrc = 1'b1; ctrl_d.memwrite = 1'b1; reads_rt = 1'b1; end
         6'h04: begin ctrl_d.branch = 1'b1; ctrl_d.aluop = 2'b01; reads_rt = 1'b1; end
         6'h08: begin ctrl_d.alusrc = 1'b1; ctrl_d.regwrite = 1'b1; end
         6'h02: is_jump = 1'b1;
         default: ctrl_d.illegal = 1'b1;
      endcase
   end

   assign hazard = valid_in && ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) || ((ex_rt == rt) && reads_rt));
   assign stall      = hazard && !flush;
   assign jump_taken = valid_in && is_jump && !stall && !flush;
   // Upper target bits fall back to the reset region only while IF/ID holds a bubble.
   assign jump_addr  = {(valid_in ? pc4_in[31:28] : RESET_PC_HI), instr_in[25:0], 2'b00};
   assign load_d     = valid_in && !flush && !stall;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      end else if (wb_we && (wb_addr != 5'd0)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         pc4_q     <= 32'd0;
         rs_data_q <= 32'd0;
         rt_data_q <= 32'd0;
         imm_q     <= 32'd0;
         rs_q      <= 5'd0;
         rt_q      <= 5'd0;
         rd_q      <= 5'd0;
      end else if (!load_d) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         valid_q   <= 1'b1;
         ctrl_q    <= ctrl_d;
         pc4_q     <= pc4_in;
         rs_data_q <= rs_data;
         rt_data_q <= rt_data;
         imm_q     <= imm_ext;
         rs_q      <= rs;
         rt_q      <= rt;
         rd_q      <= rd;
      end
   end

   assign idex.idex_valid    = valid_q;
   assign idex.idex_pc4      = pc4_q;
   assign idex.idex_rs_data  = rs_data_q;
   assign idex.idex_rt_data  = rt_data_q;
   assign idex.idex_imm      = imm_q;
   assign idex.idex_rs       = rs_q;
   assign idex.idex_rt       = rt_q;
   assign idex.idex_rd       = rd_q;
   assign idex.idex_regdst   = ctrl_q.regdst;
   assign idex.idex_alusrc   = ctrl_q.alusrc;
   assign idex.idex_memread  = ctrl_q.memread;
   assign idex.idex_memwrite = ctrl_q.memwrite;
   assign idex.idex_regwrite = ctrl_q.regwrite;
   assign idex.idex_memtoreg = ctrl_q.memtoreg;
   assign idex.idex_branch   = ctrl_q.branch;
   assign idex.idex_aluop    = ctrl_q.aluop;
   assign idex.idex_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed cases plus random traffic, checked by a
// register-array reference model and an expected-response queue drained by a monitor.
`timescale 1ns/1ps
module tb_inst_decode_stage;

   typedef struct packed {
      logic        valid;
      logic [9:0]  ctrl;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc4_in = '0, instr_in = '0, wb_data = '0;
   logic        valid_in = 1'b0, flush = 1'b0, ex_memread = 1'b0, wb_we = 1'b0;
   logic [4:0]  ex_rt = '0, wb_addr = '0;
   logic        stall, jump_taken;
   logic [31:0] jump_addr;

   inst_decode_stage_if idex_bus ();

   inst_decode_stage dut (
      .clk(clk), .rstn(rstn), .pc4_in(pc4_in), .instr_in(instr_in),
      .valid_in(valid_in), .flush(flush), .ex_memread(ex_memread), .ex_rt(ex_rt),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .jump_taken(jump_taken), .jump_addr(jump_addr),
      .idex(idex_bus)
   );

   // Clock / reset
   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard state and reference model
   exp_t        exp_q [$];
   logic [31:0] mregs [32];
   int          tests_run = 0;
   int          tests_failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // {regdst,alusrc,memread,memwrite,regwrite,memtoreg,branch,aluop[1:0],illegal}
   function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'h00:   return 10'b1000100_10_0;
         6'h23:   return 10'b0110110_00_0;
         6'h2B:   return 10'b0101000_00_0;
         6'h04:   return 10'b0000001_01_0;
         6'h08:   return 10'b0100100_00_0;
         6'h02:   return 10'b0000000_00_0;
         default: return 10'b0000000_00_1;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_we && wb_addr == idx) return wb_data;
      return mregs[idx];
   endfunction

   // Driver: apply one IF/ID cycle, check combinational outputs, queue the ID/EX result
   task automatic drive(input logic [31:0] pc4, input logic [31:0] instr, input logic vld,
                        input logic fl, input logic exmr, input logic [4:0] exrt,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t        e;
      logic [5:0]  op;
      logic [4:0]  rs, rt;
      logic        rdrt, hz, st, jt;
      @(negedge clk);
      pc4_in = pc4; instr_in = instr; valid_in = vld; flush = fl;
      ex_memread = exmr; ex_rt = exrt; wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
      op   = instr[31:26];
      rs   = instr[25:21];
      rt   = instr[20:16];
      rdrt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      hz   = vld && exmr && exrt != 0 && (exrt == rs || (exrt == rt && rdrt));
      st   = hz && !fl;
      jt   = vld && op == 6'h02 && !st && !fl;
      check("stall", 64'(stall), 64'(st));
      check("jump_taken", 64'(jump_taken), 64'(jt));
      if (vld) check("jump_addr", 64'(jump_addr), 64'({pc4[31:28], instr[25:0], 2'b00}));
      e.valid   = vld && !fl && !st;
      e.ctrl    = e.valid ? ref_ctrl(op) : 10'd0;
      e.pc4     = pc4;
      e.rs_data = ref_read(rs);
      e.rt_data = ref_read(rt);
      e.imm     = 32'($signed(instr[15:0]));
      e.rs      = rs;
      e.rt      = rt;
      e.rd      = instr[15:11];
      exp_q.push_back(e);
      if (we && wa != 0) mregs[wa] = wd;
   endtask

   // Monitor: one ID/EX result per clock edge after reset
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rstn && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("idex_valid", 64'(idex_bus.idex_valid), 64'(e.valid));
         check("idex_ctrl", 64'({idex_bus.idex_regdst, idex_bus.idex_alusrc,
               idex_bus.idex_memread, idex_bus.idex_memwrite, idex_bus.idex_regwrite,
               idex_bus.idex_memtoreg, idex_bus.idex_branch, idex_bus.idex_aluop,
               idex_bus.idex_illegal}), 64'(e.ctrl));
         if (e.valid) begin
            check("idex_pc4", 64'(idex_bus.idex_pc4), 64'(e.pc4));
            check("idex_rs_data", 64'(idex_bus.idex_rs_data), 64'(e.rs_data));
            check("idex_rt_data", 64'(idex_bus.idex_rt_data), 64'(e.rt_data));
            check("idex_imm", 64'(idex_bus.idex_imm), 64'(e.imm));
            check("idex_regs", 64'({idex_bus.idex_rs, idex_bus.idex_rt, idex_bus.idex_rd}),
                  64'({e.rs, e.rt, e.rd}));
         end
      end
   end

   task automatic check_idex_zero(input string tag);
      check({tag, "_valid_ctrl"}, 64'({idex_bus.idex_valid, idex_bus.idex_regdst,
            idex_bus.idex_alusrc, idex_bus.idex_memread, idex_bus.idex_memwrite,
            idex_bus.idex_regwrite, idex_bus.idex_memtoreg, idex_bus.idex_branch,
            idex_bus.idex_aluop, idex_bus.idex_illegal}), 64'd0);
      check({tag, "_data"}, 64'(idex_bus.idex_pc4 | idex_bus.idex_rs_data |
            idex_bus.idex_rt_data | idex_bus.idex_imm), 64'd0);
      check({tag, "_idx"}, 64'({idex_bus.idex_rs, idex_bus.idex_rt, idex_bus.idex_rd}), 64'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [7];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
      return {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
   endfunction

   localparam logic [31:0] ADD_9_8_8 = 32'h0108_4820;
   localparam logic [31:0] SW_8_9    = 32'hAD28_0000;
   localparam logic [31:0] ADDI_8_9  = 32'h2128_0004;
   localparam logic [31:0] J_TGT     = 32'h0810_0040;
   localparam logic [31:0] J_RS9     = 32'h0920_0000;

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      check_idex_zero("reset");
      @(negedge clk);
      rstn = 1'b1;

      drive(32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h1234);
      drive(32'h8, ADD_9_8_8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      drive(32'hC, ADD_9_8_8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 32'hBEEF);
      drive(32'h10, 32'h0000_4820, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      drive(32'h14, 32'h0000_4820, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      drive(32'h18, SW_8_9, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
      check("loaduse_sw_stall", 64'(stall), 64'd1);
      drive(32'h1C, ADDI_8_9, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
      check("loaduse_addi_nostall", 64'(stall), 64'd0);
      drive(32'h20, SW_8_9, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
      check("flush_hazard_nostall", 64'(stall), 64'd0);
      drive(32'h24, ADD_9_8_8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      drive(32'h9000_0008, J_TGT, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      check("j_addr_const", 64'(jump_addr), 64'h9040_0100);
      check("j_taken_const", 64'(jump_taken), 64'd1);
      drive(32'h9000_0008, J_TGT, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      drive(32'h9000_000C, J_RS9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
      check("j_stalled_not_taken", 64'(jump_taken), 64'd0);
      drive(32'h30, 32'hFC00_1234, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h5555);

      // Asynchronous reset pulse between edges
      @(posedge clk);
      #2 rstn = 1'b0;
      #2 check_idex_zero("midrun_reset");
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      #1 rstn = 1'b1;
      drive(32'h40, 32'h00A0_4820, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         drive($urandom, rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
